// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor and redirect controller.
// Counter encodings, FSM states and the B-type func3 codes live here.
package branch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2
   } bp_state_t;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } br_func3_t;

   function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // A taken branch resumes at its target; a not-taken one at the next word.
   function automatic logic [31:0] correct_pc(input logic        cond,
                                              input logic [31:0] pc,
                                              input logic [31:0] target);
      return cond ? target : fallthrough_pc(pc);
   endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat.sv
// 2-bit saturating up/down counter update used on the training path.
module sat_counter2
   import branch_pkg::*;
(
   input  logic [1:0] count,
   input  logic       up,
   output logic [1:0] count_next
);

   always_comb begin
      count_next = count;
      if (up) begin
         if (count != ST) count_next = count + 2'd1;
      end else begin
         if (count != SNT) count_next = count - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch prediction table plus mispredict redirect/flush sequencer.
// Predicts in IF, trains from EX, and redirects fetch on a wrong guess.
module branch_predict_ctrl
   import branch_pkg::*;
#(
   parameter int BHT_ENTRIES  = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_cond,
   input  logic        ex_pred_taken,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic [31:0] br_count,
   output logic [31:0] mispred_count
);

   localparam int IDX_W   = $clog2(BHT_ENTRIES);
   localparam int DRAIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(FLUSH_CYCLES - 1);

   logic [1:0]         bht [BHT_ENTRIES];
   logic [IDX_W-1:0]   if_idx;
   logic [IDX_W-1:0]   ex_idx;
   logic [1:0]         trained;
   logic               resolve;
   logic               mispredict;
   logic               unused_if_bits;

   bp_state_t          state;
   bp_state_t          state_next;
   logic [DRAIN_W-1:0] drain;
   logic [DRAIN_W-1:0] drain_next;
   logic               redirect_next;
   logic               flush_next;
   logic [31:0]        redirect_pc_next;

   assign if_idx         = if_pc[IDX_W+1:2];
   assign ex_idx         = ex_pc[IDX_W+1:2];
   assign unused_if_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

   // Table read is a plain mux, so a same-cycle update is not yet visible.
   assign pred_taken = bht[if_idx][1];

   // Anything arriving while a redirect is in flight is wrong-path.
   assign resolve    = ex_valid & ex_is_branch & (state == IDLE);
   assign mispredict = resolve & (ex_cond != ex_pred_taken);

   sat_counter2 u_train (
      .count      (bht[ex_idx]),
      .up         (ex_cond),
      .count_next (trained)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
      end else if (resolve) begin
         bht[ex_idx] <= trained;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         if (resolve && br_count != '1) br_count <= br_count + 32'd1;
         if (mispredict && mispred_count != '1) mispred_count <= mispred_count + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         drain       <= '0;
         redirect    <= 1'b0;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         state       <= state_next;
         drain       <= drain_next;
         redirect    <= redirect_next;
         flush       <= flush_next;
         redirect_pc <= redirect_pc_next;
      end
   end

   // Outputs are registered, so flush_next describes the cycle after this one.
   always_comb begin
      state_next       = state;
      drain_next       = drain;
      redirect_next    = 1'b0;
      flush_next       = 1'b0;
      redirect_pc_next = redirect_pc;
      case (state)
         IDLE: begin
            if (mispredict) begin
               redirect_pc_next = correct_pc(ex_cond, ex_pc, ex_target);
               redirect_next    = 1'b1;
               flush_next       = 1'b1;
               drain_next       = DRAIN_INIT;
               state_next       = REDIRECT;
            end
         end
         REDIRECT: begin
            if (drain == '0) begin
               state_next = IDLE;
            end else begin
               drain_next = drain - DRAIN_W'(1);
               flush_next = 1'b1;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (drain == '0) begin
               state_next = IDLE;
            end else begin
               drain_next = drain - DRAIN_W'(1);
               flush_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
